cordic_fix2float: RTL

- Output stage placed directly after the CORDIC core.
- Takes the core's signed fixed-point result (INTS integer bits, FRACS fraction bits, sign bit) when the core asserts done, and converts it to an IEEE-754 single-precision word for the custom-instruction result bus.
- Normalisation is sequential: one leading-zero shift per cycle, driven by a small FSM with start/done handshake.

---
 rtl/cordic_pkg.sv | 24 ++
 rtl/cordic_lzc.sv | 19 +
 rtl/cordic_fix2float.sv | 121 ++++++++++++
 3 files changed

// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: fixed-point format defaults, IEEE-754 single fields and
// the fix2float FSM state encoding.
package cordic_pkg;

    localparam int unsigned CORDIC_FRACS = 22;
    localparam int unsigned CORDIC_INTS  = 1;

    localparam int unsigned FP_BIAS  = 127;
    localparam int unsigned FP_EXP_W = 8;
    localparam int unsigned FP_MAN_W = 23;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        OUT  = 2'd2
    } fix2float_state_t;

    typedef struct packed {
        logic                sign;
        logic [FP_EXP_W-1:0] expo;
        logic [FP_MAN_W-1:0] mant;
    } fp32_t;

endpackage

// File: rtl/cordic_lzc.sv
// Leading-zero counter: number of zeros above the highest set bit (WIDTH when all zero).
module cordic_lzc #(
    parameter int unsigned WIDTH = 24
) (
    input  logic [WIDTH-1:0] value,
    output logic [4:0]       count_c
);

    // Later iterations overwrite earlier ones, so the highest set bit wins.
    always_comb begin
        count_c = 5'(WIDTH);
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (value[i]) begin
                count_c = 5'(int'(WIDTH) - 1 - i);
            end
        end
    end

endmodule

// File: rtl/cordic_fix2float.sv
// Converts the CORDIC core's signed fixed-point result to an IEEE-754 single.
// Define CORDIC_FIX2FLOAT_FAST_NORM_EN for single-cycle normalisation via cordic_lzc.
module cordic_fix2float
    import cordic_pkg::*;
#(
    parameter int unsigned FRACS = CORDIC_FRACS,
    parameter int unsigned INTS  = CORDIC_INTS,
    parameter int unsigned WIDTH = INTS + FRACS + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_en,
    input  logic             start,
    input  logic [WIDTH-1:0] fixedPoint_in,
    output logic             busy,
    output logic             done,
    output logic [31:0]      result
);

    localparam logic [FP_EXP_W-1:0] EXP_INIT = FP_EXP_W'(FP_BIAS + INTS);
    localparam int unsigned         MAN_PAD  = FP_MAN_W - (WIDTH - 1);

    fix2float_state_t    state, state_nxt;
    logic [WIDTH-1:0]    mag, mag_nxt;
    logic [FP_EXP_W-1:0] expo, expo_nxt;
    logic                sign, sign_nxt;
    fp32_t               result_q, result_nxt;
    logic                busy_nxt, done_nxt;

    // Drop the implicit leading one and left-align the remaining bits in the mantissa.
    function automatic fp32_t pack_fp(input logic s, input logic [FP_EXP_W-1:0] e,
                                      input logic [WIDTH-1:0] m);
        fp32_t f;
        f.sign = s;
        f.expo = e;
        f.mant = FP_MAN_W'(m[WIDTH-2:0]) << MAN_PAD;
        return f;
    endfunction

`ifdef CORDIC_FIX2FLOAT_FAST_NORM_EN
    logic [4:0] lz;

    cordic_lzc #(.WIDTH(WIDTH)) u_lzc (
        .value   (mag),
        .count_c (lz)
    );
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            mag      <= '0;
            expo     <= '0;
            sign     <= 1'b0;
            result_q <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else if (clk_en) begin
            state    <= state_nxt;
            mag      <= mag_nxt;
            expo     <= expo_nxt;
            sign     <= sign_nxt;
            result_q <= result_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        mag_nxt    = mag;
        expo_nxt   = expo;
        sign_nxt   = sign;
        result_nxt = result_q;

        case (state)
            IDLE: begin
                if (start) begin
                    sign_nxt  = fixedPoint_in[WIDTH-1];
                    // Negating the most negative value wraps to 2^(WIDTH-1), the correct magnitude.
                    mag_nxt   = fixedPoint_in[WIDTH-1] ? WIDTH'(-fixedPoint_in) : fixedPoint_in;
                    expo_nxt  = EXP_INIT;
                    state_nxt = NORM;
                end
            end
            NORM: begin
`ifdef CORDIC_FIX2FLOAT_FAST_NORM_EN
                if (mag == '0) begin
                    result_nxt = '0;
                end else begin
                    result_nxt = pack_fp(sign, expo - FP_EXP_W'(lz), mag << lz);
                end
                state_nxt = OUT;
`else
                if (mag == '0) begin
                    result_nxt = '0;
                    state_nxt  = OUT;
                end else if (mag[WIDTH-1]) begin
                    result_nxt = pack_fp(sign, expo, mag);
                    state_nxt  = OUT;
                end else begin
                    mag_nxt  = mag << 1;
                    expo_nxt = expo - FP_EXP_W'(1);
                end
`endif
            end
            OUT: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
        done_nxt = (state_nxt == OUT);
    end

    assign result = result_q;

endmodule
